d_cache_ctrl: RTL and testbench



---
 rtl/d_cache_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_d_cache_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Connects a 16-bit CPU data port to a 64-bit line-wide memory interface.
// Hits complete combinationally in IDLE. Misses optionally write back the
// dirty victim (WRITEBACK), then fetch the new line (FILL), then complete
// the CPU access in a one-cycle RESPOND state.
module d_cache_ctrl #(
  parameter int INDEX_BITS  = 2,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        d_readM,
  output logic        d_writeM,
  output logic [15:0] d_address,
  inout  wire  [63:0] d_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS - 2;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;
  state_t state;

  // Line state: valid/dirty are control (reset), tags/data are not cleared
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  // Memory-request cycle counter and the operands latched on a miss
  logic [3:0]            cnt;
  logic [INDEX_BITS-1:0] lat_index;
  logic [TAG_W-1:0]      lat_tag;
  logic [1:0]            lat_word;
  logic [15:0]           lat_wdata;
  logic                  lat_write;

  logic [1:0]            req_word;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  req;
  logic                  req_write;
  logic                  idle_hit;
  logic                  idle_miss;

  function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] w);
    logic [15:0] r;
    case (w)
      2'd0:    r = line[15:0];
      2'd1:    r = line[31:16];
      2'd2:    r = line[47:32];
      default: r = line[63:48];
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic [1:0] w,
                                             input logic [15:0] wd);
    logic [63:0] m;
    m = line;
    case (w)
      2'd0:    m[15:0]  = wd;
      2'd1:    m[31:16] = wd;
      2'd2:    m[47:32] = wd;
      default: m[63:48] = wd;
    endcase
    return m;
  endfunction

  // A simultaneous read and write is handled as a write
  assign req_word  = cpu_address[1:0];
  assign req_index = cpu_address[INDEX_BITS+1:2];
  assign req_tag   = cpu_address[15:INDEX_BITS+2];
  assign req       = cpu_read | cpu_write;
  assign req_write = cpu_write;
  assign idle_hit  = (state == IDLE) && req && valid[req_index] &&
                     (tag_mem[req_index] == req_tag);
  assign idle_miss = (state == IDLE) && req && !idle_hit;

  // The victim line is not modified during WRITEBACK, so it can drive the bus directly
  assign d_data = d_writeM ? data_mem[lat_index] : 64'bz;

  // CPU handshake: same-cycle completion on a hit, or the RESPOND cycle after a miss
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = 16'h0000;
    if (idle_hit) begin
      cpu_ready = 1'b1;
      if (!req_write) cpu_rdata = word_of(data_mem[req_index], req_word);
    end else if (state == RESPOND) begin
      cpu_ready = 1'b1;
      if (!lat_write) cpu_rdata = word_of(data_mem[lat_index], lat_word);
    end
  end

  // Control FSM with registered memory requests; reset drops any transfer in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      d_readM    <= 1'b0;
      d_writeM   <= 1'b0;
      d_address  <= 16'h0000;
      cnt        <= 4'd0;
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit) begin
            hit_count <= hit_count + 16'd1;
            if (req_write) dirty[req_index] <= 1'b1;
          end else if (req) begin
            miss_count <= miss_count + 16'd1;
            cnt        <= 4'd0;
            if (valid[req_index] && dirty[req_index]) begin
              state     <= WRITEBACK;
              d_writeM  <= 1'b1;
              d_address <= {tag_mem[req_index], req_index, 2'b00};
            end else begin
              state     <= FILL;
              d_readM   <= 1'b1;
              d_address <= {req_tag, req_index, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (cnt == LAST_CNT) begin
            // Back-to-back into FILL: no idle cycle between the two requests
            cnt       <= 4'd0;
            d_writeM  <= 1'b0;
            d_readM   <= 1'b1;
            d_address <= {lat_tag, lat_index, 2'b00};
            state     <= FILL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FILL: begin
          if (cnt == LAST_CNT) begin
            cnt              <= 4'd0;
            d_readM          <= 1'b0;
            valid[lat_index] <= 1'b1;
            dirty[lat_index] <= 1'b0;
            state            <= RESPOND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESPOND: begin
          if (lat_write) dirty[lat_index] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: miss operand latch, hit/respond word merges and line capture at end of FILL
  always_ff @(posedge clk) begin
    if (idle_miss) begin
      lat_index <= req_index;
      lat_tag   <= req_tag;
      lat_word  <= req_word;
      lat_wdata <= cpu_wdata;
      lat_write <= req_write;
    end
    if (idle_hit && req_write) begin
      data_mem[req_index] <= merge_word(data_mem[req_index], req_word, cpu_wdata);
    end
    if (state == FILL && cnt == LAST_CNT) begin
      data_mem[lat_index] <= d_data;
      tag_mem[lat_index]  <= lat_tag;
    end
    if (state == RESPOND && lat_write) begin
      data_mem[lat_index] <= merge_word(data_mem[lat_index], lat_word, lat_wdata);
    end
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb_d_cache_ctrl: scoreboard bench for d_cache_ctrl with a line-wide memory model.
module tb_d_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  wire  [63:0] d_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic [15:0] mem [0:255];
  logic [7:0]  base;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        chk_rdata;
    logic [15:0] rdata;
    int          start;
    int          lat;
  } cpu_exp_t;

  typedef struct {
    logic        is_write;
    logic [15:0] addr;
    logic [63:0] data;
    int          len;
  } bus_exp_t;

  cpu_exp_t cpu_q[$];
  bus_exp_t bus_q[$];

  d_cache_ctrl #(.INDEX_BITS(2), .MEM_LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
    .d_data(d_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns the addressed line while d_readM, absorbs lines while d_writeM
  assign base   = d_address[7:0];
  assign d_data = d_readM ? {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]} : 64'bz;

  always @(posedge clk) begin
    if (d_writeM) begin
      mem[base]        <= d_data[15:0];
      mem[base + 8'd1] <= d_data[31:16];
      mem[base + 8'd2] <= d_data[47:32];
      mem[base + 8'd3] <= d_data[63:48];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // CPU-side monitor: every cpu_ready pops one expected completion
  cpu_exp_t ce;
  always @(negedge clk) begin
    if (reset_n && cpu_ready) begin
      if (cpu_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got cpu_ready=1 at cycle %0d, expected no completion", cyc);
      end else begin
        ce = cpu_q.pop_front();
        check("latency", 64'(cyc - ce.start), 64'(ce.lat));
        if (ce.chk_rdata) check("cpu_rdata", {48'h0, cpu_rdata}, {48'h0, ce.rdata});
      end
    end
  end

  // Bus-side monitor: groups consecutive request cycles into bursts and checks each one
  logic        in_burst = 1'b0;
  logic        b_write;
  logic        b_stable;
  logic [15:0] b_addr;
  logic [63:0] b_data;
  int          b_len;
  bus_exp_t    be;

  task automatic end_burst();
    if (bus_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_bus: got %s burst at %h, expected none", b_write ? "write" : "read", b_addr);
    end else begin
      be = bus_q.pop_front();
      check("bus_kind", {63'h0, b_write}, {63'h0, be.is_write});
      check("bus_addr", {48'h0, b_addr}, {48'h0, be.addr});
      check("bus_len", 64'(b_len), 64'(be.len));
      check("bus_stable", {63'h0, b_stable}, 64'h1);
      if (be.is_write) check("bus_wdata", b_data, be.data);
    end
  endtask

  always @(negedge clk) begin
    if (d_readM || d_writeM) begin
      check("rd_wr_exclusive", {63'h0, d_readM & d_writeM}, 64'h0);
      if (in_burst && b_write == d_writeM) begin
        b_len++;
        if (d_address !== b_addr || (d_writeM && d_data !== b_data)) b_stable = 1'b0;
      end else begin
        if (in_burst) end_burst();
        in_burst = 1'b1;
        b_write  = d_writeM;
        b_addr   = d_address;
        b_data   = d_data;
        b_len    = 1;
        b_stable = 1'b1;
      end
    end else if (in_burst) begin
      end_burst();
      in_burst = 1'b0;
    end
  end

  task automatic exp_bus(input logic w, input logic [15:0] addr, input logic [63:0] data, input int len);
    bus_exp_t e;
    e.is_write = w;
    e.addr     = addr;
    e.data     = data;
    e.len      = len;
    bus_q.push_back(e);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic chk, input logic [15:0] exp_rd, input int lat);
    cpu_exp_t e;
    bit done;
    @(posedge clk);
    #1;
    cpu_read    = rd;
    cpu_write   = wr;
    cpu_address = addr;
    cpu_wdata   = wd;
    e.chk_rdata = chk;
    e.rdata     = exp_rd;
    e.start     = cyc;
    e.lat       = lat;
    cpu_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      $display("FAIL timeout: got no cpu_ready for %h within 40 cycles, expected completion", addr);
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic check_counts(input logic [15:0] hits, input logic [15:0] misses);
    check("hit_count", {48'h0, hit_count}, {48'h0, hits});
    check("miss_count", {48'h0, miss_count}, {48'h0, misses});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h23] = 16'h6000;
    for (int i = 0; i < 4; i++) begin
      mem[8'h60 + 8'(i)] = 16'h0A00 + 16'(i);
      mem[8'hA4 + 8'(i)] = 16'hB000 + 16'(i);
      mem[8'h14 + 8'(i)] = 16'hC014 + 16'(i);
    end

    // Reset state
    #12;
    check("rst_cpu_ready", {63'h0, cpu_ready}, 64'h0);
    check("rst_cpu_rdata", {48'h0, cpu_rdata}, 64'h0);
    check("rst_d_readM", {63'h0, d_readM}, 64'h0);
    check("rst_d_writeM", {63'h0, d_writeM}, 64'h0);
    check("rst_d_address", {48'h0, d_address}, 64'h0);
    check_counts(16'd0, 16'd0);
    #10;
    reset_n = 1'b1;

    // Clean read miss, then read hit on the same line
    exp_bus(1'b0, 16'h0020, 64'h0, 4);
    access(1'b1, 1'b0, 16'h0023, 16'h0, 1'b1, 16'h6000, 5);
    check_counts(16'd0, 16'd1);
    access(1'b1, 1'b0, 16'h0022, 16'h0, 1'b1, 16'h0000, 0);
    check_counts(16'd1, 16'd1);

    // Write hit dirties line 0, then a conflicting read evicts it
    access(1'b0, 1'b1, 16'h0021, 16'h1234, 1'b0, 16'h0, 0);
    check_counts(16'd2, 16'd1);
    exp_bus(1'b1, 16'h0020, 64'h6000_0000_1234_0000, 4);
    exp_bus(1'b0, 16'h0060, 64'h0, 4);
    access(1'b1, 1'b0, 16'h0061, 16'h0, 1'b1, 16'h0A01, 9);
    check_counts(16'd2, 16'd2);
    check("mem_writeback", {48'h0, mem[8'h21]}, 64'h1234);

    // Write miss with clean victim, read back, then a read+write hit
    exp_bus(1'b0, 16'h00A4, 64'h0, 4);
    access(1'b0, 1'b1, 16'h00A5, 16'h5555, 1'b0, 16'h0, 5);
    check_counts(16'd2, 16'd3);
    access(1'b1, 1'b0, 16'h00A5, 16'h0, 1'b1, 16'h5555, 0);
    check_counts(16'd3, 16'd3);
    access(1'b1, 1'b1, 16'h00A6, 16'h7777, 1'b0, 16'h0, 0);
    check_counts(16'd4, 16'd3);

    // Evict line 1: the write-back carries both stored words
    exp_bus(1'b1, 16'h00A4, 64'hB003_7777_5555_B000, 4);
    exp_bus(1'b0, 16'h0014, 64'h0, 4);
    access(1'b1, 1'b0, 16'h0015, 16'h0, 1'b1, 16'hC015, 9);
    check_counts(16'd4, 16'd4);

    // Reset in the 2nd FILL cycle: the read burst is cut after one observed cycle
    exp_bus(1'b0, 16'h0020, 64'h0, 1);
    @(posedge clk);
    #1;
    cpu_read    = 1'b1;
    cpu_address = 16'h0023;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_d_readM", {63'h0, d_readM}, 64'h0);
    check("abort_cpu_ready", {63'h0, cpu_ready}, 64'h0);
    check("abort_d_address", {48'h0, d_address}, 64'h0);
    check_counts(16'd0, 16'd0);
    cpu_read = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // After reset the line is gone; memory holds the earlier write-back
    exp_bus(1'b0, 16'h0020, 64'h0, 4);
    access(1'b1, 1'b0, 16'h0023, 16'h0, 1'b1, 16'h6000, 5);
    check_counts(16'd0, 16'd1);
    access(1'b1, 1'b0, 16'h0021, 16'h0, 1'b1, 16'h1234, 0);
    check_counts(16'd1, 16'd1);

    repeat (3) @(posedge clk);
    check("cpu_q_drained", 64'(cpu_q.size()), 64'h0);
    check("bus_q_drained", 64'(bus_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
